// File: rtl/divider_pkg.sv
// Shared constants and FSM encoding for the iterative signed divider.
package divider_pkg;
  localparam int unsigned WidthDefault = 32;
  localparam int unsigned Iterations   = 32;
  localparam int unsigned CntWidth     = $clog2(Iterations);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;
endpackage

// File: rtl/divider_if.sv
// Start/operand and result signals of the divider, grouped for master and slave sides.
interface divider_if
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) ();
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_DIV,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  ctrl_DIV,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/cla.sv
// Adder with carries formed from per-bit generate/propagate terms.
module cla #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_sum  = w_p ^ w_c[WIDTH-1:0];
  assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/div_step.sv
// One unsigned restoring shift-subtract iteration: yields the next remainder and one quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_no_borrow;
  logic           w_unused_diff_msb;

  assign w_shift = {i_rem, i_bit};

  // One extra bit so the shifted remainder cannot overflow before the compare.
  cla #(.WIDTH(WIDTH + 1)) u_sub (
    .i_a   (w_shift),
    .i_b   (~{1'b0, i_divisor}),
    .i_cin (1'b1),
    .o_sum (w_diff),
    .o_cout(w_no_borrow)
  );

  assign w_unused_diff_msb = w_diff[WIDTH];
  assign o_qbit            = w_no_borrow;
  assign o_rem             = w_no_borrow ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule

// File: rtl/divider.sv
// Signed 32-cycle restoring divider; quotient truncated toward zero, remainder discarded.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input logic      clock,
  input logic      reset,
  divider_if.slave bus
);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  state_e              r_state;
  logic [CntWidth-1:0] r_cnt;
  logic [WIDTH-1:0]    r_dvd;
  logic [WIDTH-1:0]    r_dvs;
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH-2:0]    r_quot;
  logic                r_neg;
  logic                r_div_zero;
  logic                r_ovf;
  logic [WIDTH-1:0]    r_result;
  logic                r_exc;
  logic                r_rdy;

  logic [WIDTH-1:0] w_a_neg, w_b_neg, w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_rem_next, w_quot_next, w_quot_neg, w_final;
  logic             w_qbit, w_b_zero, w_ovf;
  logic             w_unused_cout_a, w_unused_cout_b, w_unused_cout_q;

  cla #(.WIDTH(WIDTH)) u_neg_a (
    .i_a   (~bus.data_operandA),
    .i_b   ('0),
    .i_cin (1'b1),
    .o_sum (w_a_neg),
    .o_cout(w_unused_cout_a)
  );

  cla #(.WIDTH(WIDTH)) u_neg_b (
    .i_a   (~bus.data_operandB),
    .i_b   ('0),
    .i_cin (1'b1),
    .o_sum (w_b_neg),
    .o_cout(w_unused_cout_b)
  );

  // Negating 0x80000000 wraps to itself, which is the correct unsigned 2^31 magnitude.
  assign w_a_mag  = bus.data_operandA[WIDTH-1] ? w_a_neg : bus.data_operandA;
  assign w_b_mag  = bus.data_operandB[WIDTH-1] ? w_b_neg : bus.data_operandB;
  assign w_b_zero = (bus.data_operandB == '0);
  assign w_ovf    = (bus.data_operandA == MinNeg) && (bus.data_operandB == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_dvd[WIDTH-1]),
    .i_divisor(r_dvs),
    .o_rem    (w_rem_next),
    .o_qbit   (w_qbit)
  );

  assign w_quot_next = {r_quot, w_qbit};

  cla #(.WIDTH(WIDTH)) u_neg_q (
    .i_a   (~w_quot_next),
    .i_b   ('0),
    .i_cin (1'b1),
    .o_sum (w_quot_neg),
    .o_cout(w_unused_cout_q)
  );

  always_comb begin
    w_final = r_neg ? w_quot_neg : w_quot_next;
    if (r_div_zero) begin
      w_final = '0;
    end else if (r_ovf) begin
      w_final = MinNeg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_neg      <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
      r_exc      <= 1'b0;
      r_rdy      <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      // A start pulse in any state aborts whatever is in flight.
      if (bus.ctrl_DIV) begin
        r_state    <= StRun;
        r_cnt      <= '0;
        r_dvd      <= w_a_mag;
        r_dvs      <= w_b_mag;
        r_rem      <= '0;
        r_quot     <= '0;
        r_neg      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        r_div_zero <= w_b_zero;
        r_ovf      <= w_ovf;
      end else begin
        case (r_state)
          StRun: begin
            r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next[WIDTH-2:0];
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CntWidth'(Iterations - 1)) begin
              r_state  <= StDone;
              r_result <= w_final;
              r_exc    <= r_div_zero | r_ovf;
              r_rdy    <= 1'b1;
            end
          end
          StDone:  r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the divider: latency, results, exceptions, abort and reset behaviour.
module tb_divider;
  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  divider_if #(.WIDTH(32)) bus ();

  divider #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge right after the start edge (E0).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
  endtask

  // exp_lat = 0 means no ready pulse is allowed and all outputs must be zero.
  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_res,
                             input logic exp_exc);
    int          first  = -1;
    int          pulses = 0;
    logic [31:0] res    = '0;
    logic        exc    = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        pulses++;
        if (first < 0) begin
          first = k;
          res   = bus.data_result;
          exc   = bus.data_exception;
        end
      end
    end
    if (exp_lat > 0) begin
      check({tag, "_lat"}, 32'(first), 32'(exp_lat));
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_res"}, res, exp_res);
      check({tag, "_exc"}, {31'd0, exc}, {31'd0, exp_exc});
      check({tag, "_hold"}, bus.data_result, exp_res);
    end else begin
      check({tag, "_pulses"}, 32'(pulses), 32'd0);
      check({tag, "_res"}, bus.data_result, 32'd0);
      check({tag, "_exc"}, {31'd0, bus.data_exception}, 32'd0);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    check("rst_res", bus.data_result, 32'd0);
    check("rst_exc", {31'd0, bus.data_exception}, 32'd0);
    check("rst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    reset = 1'b0;

    start_op(32'd100, 32'd7);
    wait_result("p100_7", 32, 32'd14, 1'b0);
    start_op(-32'sd100, 32'd7);
    wait_result("m100_7", 32, 32'hFFFF_FFF2, 1'b0);
    start_op(-32'sd100, -32'sd7);
    wait_result("m100_m7", 32, 32'd14, 1'b0);
    start_op(32'd5, 32'd0);
    wait_result("div0", 32, 32'd0, 1'b1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("ovf", 32, 32'h8000_0000, 1'b1);
    start_op(32'h7FFF_FFFF, 32'd1);
    wait_result("max_1", 32, 32'h7FFF_FFFF, 1'b0);
    start_op(32'd3, 32'd5);
    wait_result("p3_5", 32, 32'd0, 1'b0);
    start_op(32'h8000_0000, 32'd2);
    wait_result("min_2", 32, 32'hC000_0000, 1'b0);
    start_op(-32'sd7, 32'd2);
    wait_result("m7_2", 32, 32'hFFFF_FFFD, 1'b0);

    // Abort: second start lands on E10, only its result may appear.
    start_op(32'd1000, 32'd3);
    repeat (8) @(negedge clock);
    start_op(32'd9, 32'd3);
    wait_result("abort", 32, 32'd3, 1'b0);

    // Reset asserted at E15 of a running division.
    start_op(32'd1000, 32'd3);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_result("mid_rst", 0, 32'd0, 1'b0);

    // Start pulse during the DONE cycle: ready still shown, new division follows.
    start_op(32'd100, 32'd7);
    repeat (32) @(negedge clock);
    check("b2b_rdy", {31'd0, bus.data_resultRDY}, 32'd1);
    check("b2b_res", bus.data_result, 32'd14);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd20;
    bus.data_operandB = 32'd5;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    check("b2b_rdy_off", {31'd0, bus.data_resultRDY}, 32'd0);
    wait_result("b2b", 32, 32'd4, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clock);
    reset             = 1'b1;
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd3;
    @(negedge clock);
    reset        = 1'b0;
    bus.ctrl_DIV = 1'b0;
    wait_result("rst_prio", 0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; only 32 is required to be supported.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port data_operandA  input  WIDTH  dividend, two's complement, sampled only when ctrl_DIV is high.
REQ-005 SHALL have port data_operandB  input  WIDTH  divisor, two's complement, sampled only when ctrl_DIV is high.
REQ-006 SHALL have port ctrl_DIV  input  1  start pulse; high at a rising edge latches both operands and starts a division.
REQ-007 SHALL have port data_result  output  WIDTH  signed quotient, truncated toward zero.
REQ-008 SHALL have port data_exception  output  1  divide-by-zero or overflow flag for the current result.
REQ-009 SHALL have port data_resultRDY  output  1  one-cycle pulse marking data_result and data_exception valid.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 SHALL, at edge E0 where ctrl_DIV=1, latch |A|, |B|, sign(A) XOR sign(B) and the exception condition; clear the remainder and the 5-bit iteration count; and enter RUN.
REQ-012 SHALL perform one unsigned restoring shift-subtract iteration per RUN cycle, at edges E1..E32, producing one quotient bit per edge, MSB first.
REQ-013 SHALL enter DONE at E32 and drive data_resultRDY=1 for exactly the cycle between E32 and E33, then return to IDLE at E33 (fixed latency 32 cycles, all operand values).
REQ-014 SHALL drive data_result as the quotient negated when the latched sign bit is 1; data_result and data_exception SHALL hold from DONE until the next accepted ctrl_DIV.
REQ-015 SHALL treat B=0 as an exception: data_exception=1, data_result=0.
REQ-016 SHALL treat A=0x80000000 with B=0xFFFFFFFF as overflow: data_exception=1, data_result=0x80000000.
REQ-017 SHALL take the magnitude of 0x80000000 as unsigned 2^31 without error in all other cases.
REQ-018 SHALL discard the remainder; it is never output.
REQ-019 SHALL, on ctrl_DIV=1 during RUN or DONE, abort the current division, latch the new operands and restart at count 0; an aborted division never raises data_resultRDY.
REQ-020 SHALL still drive data_resultRDY=1 in a DONE cycle where ctrl_DIV is also high; the next division then restarts normally.
REQ-021 SHALL ignore ctrl_DIV held high for several cycles beyond restarting on each of those edges.

Reset
REQ-022 SHALL, on reset=1 at any edge, enter IDLE and clear the count, operand, remainder and quotient registers.
REQ-023 SHALL hold data_result=0, data_exception=0 and data_resultRDY=0 after reset.
REQ-024 SHALL give reset priority over a simultaneous ctrl_DIV; that start is lost.
REQ-025 SHALL, on reset mid-RUN, never emit data_resultRDY for the interrupted division.

Structure
REQ-026 SHALL place the FSM state encoding, WIDTH default (32) and iteration count (32) in a shared package.
REQ-027 SHALL put one iteration in a combinational sub-module div_step: in {remainder, dividend bit, divisor}; out {next remainder, quotient bit}.
REQ-028 SHALL build the subtract in div_step and the final sign negation from the team's existing cla adder.

Verification
REQ-029 SHALL verify A=100, B=7, ctrl_DIV at E0: data_resultRDY high only between E32 and E33, data_result=14, data_exception=0.
REQ-030 SHALL verify A=-100, B=7: data_result=0xFFFFFFF2 (-14); and A=-100, B=-7: data_result=14, with data_exception=0 in both cases.
REQ-031 SHALL verify A=5, B=0: data_resultRDY after 32 cycles, data_exception=1, data_result=0; and A=0x80000000, B=0xFFFFFFFF: data_exception=1, data_result=0x80000000.
REQ-032 SHALL verify A=1000, B=3 started, then ctrl_DIV again at E10 with A=9, B=3: single data_resultRDY at E10+32, data_result=3.
REQ-033 SHALL verify reset at E15 of a running division: no data_resultRDY within 40 cycles, and all outputs 0.
REQ-034 SHALL verify A=0x7FFFFFFF, B=1 gives data_result=0x7FFFFFFF, and A=3, B=5 gives data_result=0, with data_exception=0 in both cases.
